// File: rtl/mult_pkg.sv
// ============================================================================
// mult_pkg : shared state encoding and default width for the sequential multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mult_seq_cu.sv
// ============================================================================
// mult_seq_cu : controller FSM and iteration counter for the shift-add multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

module mult_seq_cu
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic CLK,
    input  logic reset,
    input  logic start,
    output logic load,
    output logic step,
    output logic latch_product,
    output logic busy,
    output logic done
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last;

    assign last = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CALC;
                    cnt_d   = '0;
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            // The spare encoding falls back to IDLE
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign load          = (state_q == ST_IDLE) && start;
    assign step          = (state_q == ST_CALC);
    assign latch_product = step && last;
    assign busy          = (state_q == ST_CALC) || (state_q == ST_DONE);
    assign done          = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: rtl/mult_seq.sv
// ============================================================================
// mult_seq : multi-cycle unsigned shift-add multiplier, one multiplier bit per clock
// Rev 1.0
// ============================================================================
`default_nettype none

module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic                 load, step, latch_product;
    logic [WIDTH-1:0]     mcand_q, acc_hi_q, acc_lo_q;
    logic [2*WIDTH-1:0]   product_q;
    logic [WIDTH:0]       sum_d;
    logic [2*WIDTH-1:0]   acc_d;

    mult_seq_cu #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cu (
        .CLK           (CLK),
        .reset         (reset),
        .start         (start),
        .load          (load),
        .step          (step),
        .latch_product (latch_product),
        .busy          (busy),
        .done          (done)
    );

    // Adder carry lands in the top bit and is shifted back into acc_hi
    always_comb begin
        sum_d = {1'b0, acc_hi_q};
        if (acc_lo_q[0]) begin
            sum_d = {1'b0, acc_hi_q} + {1'b0, mcand_q};
        end
        acc_d = {sum_d, acc_lo_q[WIDTH-1:1]};
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            product_q <= '0;
        end else begin
            if (load) begin
                mcand_q  <= a;
                acc_hi_q <= '0;
                acc_lo_q <= b;
            end else if (step) begin
                {acc_hi_q, acc_lo_q} <= acc_d;
            end
            if (latch_product) begin
                product_q <= acc_d;
            end
        end
    end

    assign product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_seq.sv
// ============================================================================
// tb_mult_seq : scoreboard bench for the sequential shift-add multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mult_seq;

    localparam int WIDTH   = 32;
    localparam int LATENCY = 32;

    logic                 CLK = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [WIDTH-1:0]     a = '0;
    logic [WIDTH-1:0]     b = '0;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [2*WIDTH-1:0] p;
        int                 acc;
    } exp_t;

    exp_t sb[$];

    mult_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .CLK     (CLK),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: each done pulse must match the oldest accepted request
    always @(negedge CLK) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", product, e.p);
                check("latency", 64'(cyc - e.acc), 64'(LATENCY));
            end
        end
    end

    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t e;
        @(negedge CLK);
        start = 1'b1;
        a     = x;
        b     = y;
        @(posedge CLK);
        #1;
        start = 1'b0;
        e.p   = {32'b0, x} * {32'b0, y};
        e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge CLK);
        while (!done && n < LATENCY + 8) begin
            @(negedge CLK);
            n++;
        end
        check("done_seen", {63'b0, done}, 64'd1);
    endtask

    initial begin
        exp_t e;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_product", product, 64'd0);
        reset = 1'b0;

        // Basic 3*5 with busy framing
        issue(32'd3, 32'd5);
        @(negedge CLK);
        check("busy_after_start", {63'b0, busy}, 64'd1);
        wait_done();
        @(negedge CLK);
        check("busy_after_done", {63'b0, busy}, 64'd0);
        check("done_one_cycle", {63'b0, done}, 64'd0);
        check("basic_held", product, 64'h0000_0000_0000_000F);

        // Carry path, zero and identity operands
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done();
        check("max_product", product, 64'hFFFF_FFFE_0000_0001);
        issue(32'd0, 32'h1234_5678);
        wait_done();
        issue(32'h1234_5678, 32'd1);
        wait_done();

        // Start held while busy, operands changed mid-operation
        @(negedge CLK);
        start = 1'b1;
        a     = 32'd7;
        b     = 32'd9;
        @(posedge CLK);
        #1;
        e.p   = 64'd63;
        e.acc = cyc;
        sb.push_back(e);
        for (int i = 2; i <= 10; i++) begin
            @(negedge CLK);
            if (i == 3) begin
                a = 32'd2;
                b = 32'd2;
            end
            if (i == 4) check("prev_product_held", product, 64'h0000_0000_1234_5678);
        end
        @(negedge CLK);
        start = 1'b0;
        wait_done();
        repeat (3) @(negedge CLK);
        check("busy_no_requeue", {63'b0, busy}, 64'd0);
        check("held_63", product, 64'd63);

        // Reset mid-operation aborts with no done pulse
        @(negedge CLK);
        start = 1'b1;
        a     = 32'd100;
        b     = 32'd200;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (9) @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        check("abort_product", product, 64'd0);
        reset = 1'b0;
        repeat (LATENCY + 8) @(negedge CLK);
        issue(32'd6, 32'd7);
        wait_done();
        check("after_abort", product, 64'd42);

        // Back-to-back: restart in the IDLE cycle right after done
        issue(32'd10, 32'd10);
        wait_done();
        issue(32'd11, 32'd11);
        repeat (LATENCY / 2) @(negedge CLK);
        check("b2b_first_held", product, 64'd100);
        wait_done();
        check("b2b_second", product, 64'd121);

        repeat (4) @(negedge CLK);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
